// File: rtl/miriscv_mul_pkg.sv
// Shared types and sizing for the iterative radix-4 Booth multiplier.
package miriscv_mul_pkg;

    localparam int MUL_OPW   = 33;
    localparam int MUL_ITERS = 17;
    localparam int MUL_ACCW  = 2 * MUL_OPW + 2;
    localparam int MUL_PPW   = MUL_OPW + 2;
    localparam int MUL_CNTW  = $clog2(MUL_ITERS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic zero;
        logic one;
        logic two;
        logic neg;
    } booth_ctrl_t;

endpackage

// File: rtl/miriscv_booth_r4_enc.sv
// Radix-4 Booth digit encoder: decodes one overlapping multiplier triplet and
// selects the partial product (one's complement when negative; the +1 is added by the caller).
module miriscv_booth_r4_enc
    import miriscv_mul_pkg::*;
(
    input  logic [2:0]         digit,
    input  logic [MUL_OPW-1:0] mcand,
    output booth_ctrl_t        ctrl,
    output logic [MUL_PPW-1:0] pp
);

    logic               is_zero;
    logic [MUL_PPW-1:0] mag;

    assign is_zero = (digit == 3'b000) || (digit == 3'b111);

    // NOTE: every variable is given a default before any branch so no latch is inferred.
    always_comb begin
        ctrl.zero = is_zero;
        ctrl.one  = digit[1] ^ digit[0];
        ctrl.two  = (digit == 3'b011) || (digit == 3'b100);
        ctrl.neg  = digit[2] && !is_zero;

        mag = '0;
        if (ctrl.one) begin
            mag = {{2{mcand[MUL_OPW-1]}}, mcand};
        end else if (ctrl.two) begin
            mag = {mcand[MUL_OPW-1], mcand, 1'b0};
        end
        pp = ctrl.neg ? ~mag : mag;
    end

endmodule

// File: rtl/miriscv_mul_iter.sv
// Iterative signed 33x33 multiplier, one radix-4 Booth digit per cycle (18-cycle latency).
// Optional last-result cache enabled by defining MIRISCV_MUL_RESULT_CACHE_EN.
module miriscv_mul_iter
    import miriscv_mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              mul_req_i,
    input  logic              mul_kill_i,
    input  logic [XLEN:0]     port_a_i,
    input  logic [XLEN:0]     port_b_i,
    output logic [2*XLEN-1:0] mul_result_o,
    output logic              mul_rdy_o
);

    mul_state_e            state_q, state_d;
    logic                  accept, finish, cache_hit;
    logic [MUL_OPW-1:0]    mcand_q;
    logic [MUL_OPW+1:0]    mplier_q;
    logic [MUL_CNTW-1:0]   cnt_q;
    logic [MUL_CNTW:0]     sh;
    logic [MUL_ACCW-1:0]   acc_q, acc_nxt, pp_ext, cin_ext;
    logic [2*XLEN-1:0]     result_q;
    logic [2:0]            digit;
    booth_ctrl_t           ctrl;
    logic [MUL_PPW-1:0]    pp;
    logic                  digit_active;

    // Digit i uses multiplier bits [2i+1:2i-1]; bit -1 is the appended zero.
    assign sh    = {cnt_q, 1'b0};
    assign digit = mplier_q[sh +: 3];

    miriscv_booth_r4_enc u_enc (
        .digit (digit),
        .mcand (mcand_q),
        .ctrl  (ctrl),
        .pp    (pp)
    );

    always_comb begin
        digit_active = !ctrl.zero && (ctrl.one ^ ctrl.two);
        pp_ext       = '0;
        cin_ext      = '0;
        if (digit_active) begin
            pp_ext  = {{(MUL_ACCW-MUL_PPW){pp[MUL_PPW-1]}}, pp};
            cin_ext = MUL_ACCW'(ctrl.neg);
        end
        acc_nxt = acc_q + (pp_ext << sh) + (cin_ext << sh);
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_req_i) begin
                    accept  = 1'b1;
                    state_d = cache_hit ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == MUL_CNTW'(MUL_ITERS - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Kill wins over everything, including a request in the same cycle.
        if (mul_kill_i) begin
            state_d = IDLE;
            accept  = 1'b0;
            finish  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (state_q == BUSY && !mul_kill_i) begin
                cnt_q <= cnt_q + MUL_CNTW'(1);
                acc_q <= acc_nxt;
            end
            if (finish) begin
                result_q <= acc_nxt[2*XLEN-1:0];
            end
        end
    end

    // NOTE: operand registers carry no reset; they are only read after an accept reloads them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mcand_q  <= port_a_i;
            mplier_q <= {port_b_i[XLEN], port_b_i, 1'b0};
        end
    end

`ifdef MIRISCV_MUL_RESULT_CACHE_EN
    logic [MUL_OPW-1:0] cache_a_q, cache_b_q;
    logic               cache_vld_q;

    assign cache_hit = cache_vld_q && (port_a_i == cache_a_q) && (port_b_i == cache_b_q);

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            cache_vld_q <= 1'b0;
        end else if (finish) begin
            cache_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (finish) begin
            cache_a_q <= mcand_q;
            cache_b_q <= mplier_q[MUL_OPW:1];
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign mul_result_o = result_q;
    assign mul_rdy_o    = (state_q == DONE) && !mul_kill_i;

endmodule

// File: doc/miriscv_mul_iter.md
MIRISCV_MUL_ITER -- requirements
Module: miriscv_mul_iter

Interface
REQ-001 SHALL have parameter: XLEN, 32, base operand width; operands are XLEN+1 bits wide, product is 2*XLEN bits wide.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: arstn_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: mul_req_i  input  1  operation request; held high by the MDU until mul_rdy_o is seen.
REQ-005 SHALL have port: mul_kill_i  input  1  abort the current operation.
REQ-006 SHALL have ports: port_a_i, port_b_i  input  XLEN+1  signed, pre-extended operands (MSB supplied by the MDU per MUL/MULH/MULHSU/MULHU).
REQ-007 SHALL have port: mul_result_o  output  2*XLEN  low 2*XLEN bits of the signed product port_a_i*port_b_i.
REQ-008 SHALL have port: mul_rdy_o  output  1  one-cycle pulse; mul_result_o is valid in that cycle.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-010 IDLE with mul_req_i=1 and mul_kill_i=0 SHALL capture both operands, clear the accumulator, set the iteration counter to 0 and go to BUSY.
REQ-011 BUSY SHALL retire one radix-4 Booth digit per cycle: 17 digits for 33-bit operands, with the multiplier sign-extended to 34 bits.
REQ-012 BUSY SHALL go to DONE after the iteration whose counter equals 16.
REQ-013 Latency SHALL be fixed: request accepted at cycle 0 gives mul_rdy_o=1 at cycle 18, independent of operand values.
REQ-014 DONE SHALL assert mul_rdy_o for exactly one cycle and then go to IDLE unconditionally.
REQ-015 mul_req_i high in the cycle after DONE SHALL be treated as a new operation.
REQ-016 mul_result_o SHALL hold the last completed product until the next completion; it SHALL NOT be modified by kill or by a new start.
REQ-017 Operands SHALL be sampled only at acceptance; port changes during BUSY SHALL have no effect.
REQ-018 Arithmetic SHALL be two's complement; the accumulator is at least 2*XLEN+3 bits; the output is truncated to 2*XLEN bits; no overflow flag.
REQ-019 mul_kill_i=1 in any state SHALL force IDLE at the next edge and SHALL suppress mul_rdy_o in that cycle and the next.
REQ-020 mul_kill_i SHALL have priority over mul_req_i.
REQ-021 mul_req_i=0 during BUSY SHALL NOT abort the operation; only mul_kill_i aborts.

Reset
REQ-022 arstn_i=0 at a rising edge SHALL set: state IDLE, mul_rdy_o=0, mul_result_o=0, counter=0, accumulator=0, cache-valid=0.
REQ-023 Reset during BUSY or DONE SHALL discard the operation with no mul_rdy_o pulse.

Configuration
REQ-024 Macro MIRISCV_MUL_RESULT_CACHE_EN defined SHALL add registers for the last completed operands plus a valid flag.
REQ-025 With the macro defined, an accepted request whose operands equal the cached pair while valid=1 SHALL go IDLE->DONE directly: mul_rdy_o at cycle 1, mul_result_o unchanged.
REQ-026 With the macro defined, the valid flag SHALL be set on each normal completion and cleared on reset; kill SHALL NOT clear it.
REQ-027 Macro undefined SHALL mean no cache registers and every operation takes 18 cycles.

Structure
REQ-028 Package miriscv_mul_pkg SHALL hold: FSM state enum, MUL_OPW=33, MUL_ITERS=17, MUL_ACCW.
REQ-029 Sub-module miriscv_booth_r4_enc SHALL be combinational: 3 multiplier bits in; outputs {zero, one, two, neg} plus the selected, shifted partial product.

Verification
REQ-030 Scenario: a=33'h0_00000003, b=33'h0_00000005 -> mul_rdy_o at cycle 18, result 64'h0000_0000_0000_000F.
REQ-031 Scenario: a=b=33'h0_FFFFFFFF (MULHU) -> result 64'hFFFF_FFFE_0000_0001; a=b=33'h1_80000000 -> 64'h4000_0000_0000_0000.
REQ-032 Scenario: a=33'h1_FFFFFFFF (-1), b=33'h0_00000007 -> result 64'hFFFF_FFFF_FFFF_FFF9.
REQ-033 Scenario: kill at cycle 5 of an operation -> no mul_rdy_o and result unchanged; the next request (2x3) -> 64'h6 at cycle 18 after its acceptance.
REQ-034 Scenario: arstn_i=0 at cycle 9 -> all outputs 0, state IDLE; a subsequent request completes normally.
REQ-035 Scenario: 3x5 then 3x5 again with MIRISCV_MUL_RESULT_CACHE_EN defined -> second mul_rdy_o at cycle 1, result 64'hF; macro undefined -> cycle 18.
